// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared reference-cache constants. The fill side and cache_data_mem both use
// this package, so they agree on line geometry and on the line address width.
//   PIXEL_BITS / CACHE_LINE_WDTH : pixel size and pixels per cache line
//   LINE_ADDR_WDTH               : data-memory line address width
//   BEAT_WDTH / BEATS            : external read-beat width and beats per line
package cache_line_fill_ctrl_pkg;

  localparam int PIXEL_BITS      = 8;
  localparam int CACHE_LINE_WDTH = 48;
  localparam int LINE_BITS       = PIXEL_BITS * CACHE_LINE_WDTH;

  localparam int SET_ADDR_WDTH   = 5;
  localparam int C_N_WAY         = 2;
  localparam int C_LG_BANKS      = 0;
  localparam int LINE_ADDR_WDTH  = SET_ADDR_WDTH + C_N_WAY - C_LG_BANKS;

  localparam int BEAT_WDTH       = 128;
  localparam int BEATS           = LINE_BITS / BEAT_WDTH;

  // Width of a counter that covers 0..n-1. The result is never below 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_line_fill_ctrl_packer.sv
// cache_fill_beat_packer: a beat counter and a line buffer for one cache-line
// fill. Each accepted beat goes into slot beat_cnt. Beat 0 occupies the LSBs.
//   clk, reset  : clock, asynchronous active-high reset (clears counter+buffer)
//   clear       : restart the counter at beat 0 (new fill accepted)
//   beat_valid  : a beat is accepted this cycle (already qualified by ready)
//   beat_data   : beat payload
//   beat_last   : sender's end-of-line marker
//   line_full   : the beat accepted this cycle completes the line
//   last_err    : beat_last disagrees with the beat position this cycle
//   line_data   : assembled line
module cache_fill_beat_packer
  import cache_line_fill_ctrl_pkg::*;
#(
  parameter int BEAT_WDTH = cache_line_fill_ctrl_pkg::BEAT_WDTH,
  parameter int BEATS     = cache_line_fill_ctrl_pkg::BEATS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         beat_valid,
  input  logic [BEAT_WDTH-1:0]         beat_data,
  input  logic                         beat_last,
  output logic                         line_full,
  output logic                         last_err,
  output logic [BEAT_WDTH*BEATS-1:0]   line_data
);

  localparam int CNT_W = cnt_width(BEATS);

  logic [CNT_W-1:0]           beat_cnt_q;
  logic [BEAT_WDTH*BEATS-1:0] line_q;
  logic                       is_final;

  assign is_final  = (beat_cnt_q == CNT_W'(BEATS - 1));
  // The beat count alone decides when the line ends. The last marker is only
  // checked against it.
  assign line_full = beat_valid & is_final;
  assign last_err  = beat_valid & (beat_last ^ is_final);
  assign line_data = line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
    end else if (clear) begin
      beat_cnt_q <= '0;
    end else if (beat_valid) begin
      beat_cnt_q <= is_final ? '0 : beat_cnt_q + 1'b1;
      for (int b = 0; b < BEATS; b++) begin
        if (beat_cnt_q == CNT_W'(b)) begin
          line_q[b*BEAT_WDTH +: BEAT_WDTH] <= beat_data;
        end
      end
    end
  end

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// cache_line_fill_ctrl: write-side controller for cache_data_mem.
// The controller accepts a line-fill request. It packs the returning read beats
// into one line, writes that line to the data memory in a single cycle, and
// then pulses fill_done. It also owns the data-memory address mux. During the
// write cycle the fill address wins, and any lookup in that cycle is stalled.
//   fill_req_*   : fill request (valid/ready)
//   mem_rd_*     : external read beats (valid/ready, last marker)
//   lookup_*     : lookup address/enable in, stall out
//   dm_*         : data-memory address, write data, write enable
//   fill_done_*  : registered completion pulse and line address
//   fill_err_out : sticky last-marker protocol error
//   fsm_state_out: current FSM state (debug observation)
// Handshakes: a transfer occurs on a rising edge where valid & ready are both 1.
// Ready depends only on state, never on valid. Valid need not be held, and a
// cycle with valid=0 is a bubble.
module cache_line_fill_ctrl
  import cache_line_fill_ctrl_pkg::*;
#(
  parameter int PIXEL_BITS        = cache_line_fill_ctrl_pkg::PIXEL_BITS,
  parameter int CACHE_LINE_WDTH   = cache_line_fill_ctrl_pkg::CACHE_LINE_WDTH,
  parameter int LINE_ADDR_WDTH    = cache_line_fill_ctrl_pkg::LINE_ADDR_WDTH,
  parameter int BEAT_WDTH         = cache_line_fill_ctrl_pkg::BEAT_WDTH,
  localparam int LINE_BITS        = PIXEL_BITS * CACHE_LINE_WDTH,
  localparam int BEATS            = LINE_BITS / BEAT_WDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fill_req_valid_in,
  output logic                      fill_req_ready_out,
  input  logic [LINE_ADDR_WDTH-1:0] fill_req_addr_in,
  input  logic                      mem_rd_valid_in,
  output logic                      mem_rd_ready_out,
  input  logic [BEAT_WDTH-1:0]      mem_rd_data_in,
  input  logic                      mem_rd_last_in,
  input  logic                      lookup_en_in,
  input  logic [LINE_ADDR_WDTH-1:0] lookup_addr_in,
  output logic                      lookup_stall_out,
  output logic [LINE_ADDR_WDTH-1:0] dm_addr_out,
  output logic [LINE_BITS-1:0]      dm_w_data_out,
  output logic                      dm_w_en_out,
  output logic                      fill_done_out,
  output logic [LINE_ADDR_WDTH-1:0] fill_done_addr_out,
  output logic                      fill_err_out,
  output logic [1:0]                fsm_state_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } fill_state_e;

  fill_state_e               state_q, state_d;
  logic [LINE_ADDR_WDTH-1:0] fill_addr_q;
  logic                      done_q;
  logic [LINE_ADDR_WDTH-1:0] done_addr_q;
  logic                      err_q;

  logic                      req_accept;
  logic                      beat_accept;
  logic                      line_full;
  logic                      last_err;
  logic [LINE_BITS-1:0]      line_data;

  assign req_accept  = fill_req_valid_in & fill_req_ready_out;
  assign beat_accept = mem_rd_valid_in & mem_rd_ready_out;

  cache_fill_beat_packer #(
    .BEAT_WDTH (BEAT_WDTH),
    .BEATS     (BEATS)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (req_accept),
    .beat_valid (beat_accept),
    .beat_data  (mem_rd_data_in),
    .beat_last  (mem_rd_last_in),
    .line_full  (line_full),
    .last_err   (last_err),
    .line_data  (line_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fill_addr_q <= '0;
      done_q      <= 1'b0;
      done_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_WRITE);
      if (req_accept) begin
        fill_addr_q <= fill_req_addr_in;
      end
      if (state_q == ST_WRITE) begin
        done_addr_q <= fill_addr_q;
      end
      if (last_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_accept) state_d = ST_COLLECT;
      ST_COLLECT: if (line_full)  state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The ready outputs and the lookup address pass-through are combinational,
  // so reset gates them. That keeps every output at 0 while reset is high.
  always_comb begin
    fill_req_ready_out = 1'b0;
    mem_rd_ready_out   = 1'b0;
    dm_w_en_out        = 1'b0;
    dm_w_data_out      = '0;
    dm_addr_out        = '0;
    lookup_stall_out   = 1'b0;
    if (!reset) begin
      fill_req_ready_out = (state_q == ST_IDLE);
      mem_rd_ready_out   = (state_q == ST_COLLECT);
      if (state_q == ST_WRITE) begin
        dm_w_en_out      = 1'b1;
        dm_w_data_out    = line_data;
        dm_addr_out      = fill_addr_q;
        // The data memory holds its read register during a write, so a
        // lookup issued now returns nothing and has to be re-issued.
        lookup_stall_out = lookup_en_in;
      end else begin
        dm_addr_out = lookup_addr_in;
      end
    end
  end

  assign fill_done_out      = done_q;
  assign fill_done_addr_out = done_addr_q;
  assign fill_err_out       = err_q;
  assign fsm_state_out      = state_q;

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
module tb_cache_line_fill_ctrl;
  import cache_line_fill_ctrl_pkg::*;

  localparam int AW = LINE_ADDR_WDTH;
  localparam int BW = BEAT_WDTH;
  localparam int LW = LINE_BITS;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          fill_req_valid_in;
  logic          fill_req_ready_out;
  logic [AW-1:0] fill_req_addr_in;
  logic          mem_rd_valid_in;
  logic          mem_rd_ready_out;
  logic [BW-1:0] mem_rd_data_in;
  logic          mem_rd_last_in;
  logic          lookup_en_in;
  logic [AW-1:0] lookup_addr_in;
  logic          lookup_stall_out;
  logic [AW-1:0] dm_addr_out;
  logic [LW-1:0] dm_w_data_out;
  logic          dm_w_en_out;
  logic          fill_done_out;
  logic [AW-1:0] fill_done_addr_out;
  logic          fill_err_out;
  logic [1:0]    fsm_state_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_line_fill_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .fill_req_valid_in  (fill_req_valid_in),
    .fill_req_ready_out (fill_req_ready_out),
    .fill_req_addr_in   (fill_req_addr_in),
    .mem_rd_valid_in    (mem_rd_valid_in),
    .mem_rd_ready_out   (mem_rd_ready_out),
    .mem_rd_data_in     (mem_rd_data_in),
    .mem_rd_last_in     (mem_rd_last_in),
    .lookup_en_in       (lookup_en_in),
    .lookup_addr_in     (lookup_addr_in),
    .lookup_stall_out   (lookup_stall_out),
    .dm_addr_out        (dm_addr_out),
    .dm_w_data_out      (dm_w_data_out),
    .dm_w_en_out        (dm_w_en_out),
    .fill_done_out      (fill_done_out),
    .fill_done_addr_out (fill_done_addr_out),
    .fill_err_out       (fill_err_out),
    .fsm_state_out      (fsm_state_out)
  );

  // ---------------- scoreboard ----------------
  logic [LW-1:0] exp_q[$];
  logic [AW-1:0] exp_wr_addr_q[$];
  int            exp_wr_cyc_q[$];
  logic [AW-1:0] exp_done_addr_q[$];
  int            exp_done_cyc_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: whenever the DUT writes, pulses done, or sees a lookup, compare
  // against the head of the expectation queues.
  always @(negedge clk) begin
    bit wr_now;
    bit done_now;
    if (reset !== 1'b1) begin
      wr_now   = (exp_wr_cyc_q.size() > 0) && (exp_wr_cyc_q[0] == cyc);
      done_now = (exp_done_cyc_q.size() > 0) && (exp_done_cyc_q[0] == cyc);
      if (wr_now || dm_w_en_out) begin
        check("dm_w_en", LW'(dm_w_en_out), LW'(wr_now));
        if (wr_now) begin
          check("dm_addr_write", LW'(dm_addr_out), LW'(exp_wr_addr_q[0]));
          check("dm_w_data", dm_w_data_out, exp_q[0]);
          void'(exp_q.pop_front());
          void'(exp_wr_addr_q.pop_front());
          void'(exp_wr_cyc_q.pop_front());
        end
      end
      if (lookup_en_in) begin
        check("lookup_stall", LW'(lookup_stall_out), LW'(wr_now));
        if (!wr_now) check("dm_addr_lookup", LW'(dm_addr_out), LW'(lookup_addr_in));
      end
      if (done_now || fill_done_out) begin
        check("fill_done", LW'(fill_done_out), LW'(done_now));
        if (done_now) begin
          check("fill_done_addr", LW'(fill_done_addr_out), LW'(exp_done_addr_q[0]));
          void'(exp_done_addr_q.pop_front());
          void'(exp_done_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic request(input logic [AW-1:0] addr, output int t0);
    bit got = 1'b0;
    t0 = -100;
    fill_req_valid_in = 1'b1;
    fill_req_addr_in  = addr;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (fill_req_ready_out === 1'b1) begin
        got = 1'b1;
        t0  = cyc;
      end
      @(posedge clk); #1;
    end
    fill_req_valid_in = 1'b0;
    check("req_accept", LW'(got), LW'(1));
  endtask

  task automatic beat(input logic [BW-1:0] data, input logic last, input int gap);
    for (int i = 0; i < gap; i++) begin
      mem_rd_valid_in = 1'b0;
      @(negedge clk);
      check("mem_rd_ready_gap", LW'(mem_rd_ready_out), LW'(1));
      @(posedge clk); #1;
    end
    mem_rd_valid_in = 1'b1;
    mem_rd_data_in  = data;
    mem_rd_last_in  = last;
    @(negedge clk);
    check("mem_rd_ready", LW'(mem_rd_ready_out), LW'(1));
    @(posedge clk); #1;
    mem_rd_valid_in = 1'b0;
    mem_rd_last_in  = 1'b0;
  endtask

  // wr_off: hand-computed cycle of the write relative to request acceptance.
  task automatic do_fill(input logic [AW-1:0] addr, input logic [BW-1:0] d0,
                         input logic [BW-1:0] d1, input logic [BW-1:0] d2,
                         input logic [2:0] lasts, input int gap, input int wr_off,
                         output int t0);
    request(addr, t0);
    exp_q.push_back({d2, d1, d0});
    exp_wr_addr_q.push_back(addr);
    exp_wr_cyc_q.push_back(t0 + wr_off);
    exp_done_addr_q.push_back(addr);
    exp_done_cyc_q.push_back(t0 + wr_off + 1);
    beat(d0, lasts[0], 0);
    beat(d1, lasts[1], gap);
    beat(d2, lasts[2], gap);
  endtask

  task automatic check_quiet(input string tag, input logic req_rdy);
    @(negedge clk);
    check({tag, "_req_ready"}, LW'(fill_req_ready_out), LW'(req_rdy));
    check({tag, "_mem_ready"}, LW'(mem_rd_ready_out), LW'(0));
    check({tag, "_w_en"}, LW'(dm_w_en_out), LW'(0));
    check({tag, "_w_data"}, dm_w_data_out, LW'(0));
    check({tag, "_dm_addr"}, LW'(dm_addr_out), LW'(0));
    check({tag, "_done"}, LW'(fill_done_out), LW'(0));
    check({tag, "_done_addr"}, LW'(fill_done_addr_out), LW'(0));
    check({tag, "_err"}, LW'(fill_err_out), LW'(0));
    check({tag, "_stall"}, LW'(lookup_stall_out), LW'(0));
    check({tag, "_state"}, LW'(fsm_state_out), LW'(0));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t0, ta, tb;
    reset             = 1'b1;
    fill_req_valid_in = 1'b0;
    fill_req_addr_in  = '0;
    mem_rd_valid_in   = 1'b0;
    mem_rd_data_in    = '0;
    mem_rd_last_in    = 1'b0;
    lookup_en_in      = 1'b0;
    lookup_addr_in    = 7'h55;
    @(posedge clk); #1;
    check_quiet("in_reset", 1'b0);
    @(posedge clk); #1;
    reset          = 1'b0;
    lookup_addr_in = '0;
    check_quiet("post_reset", 1'b1);
    @(posedge clk); #1;

    // Single fill: write 4 cycles after accept, done 1 cycle later.
    do_fill(7'h15, {16{8'hA0}}, {16{8'hB1}}, {16{8'hC2}}, 3'b100, 0, 4, t0);
    idle(3);

    // One idle cycle between each pair of beats: the write lands at cycle 6.
    do_fill(7'h16, {16{8'hA0}}, {16{8'hB1}}, {16{8'hC2}}, 3'b100, 1, 6, t0);
    idle(3);

    // A lookup runs in every cycle of the fill. It stalls only in the write cycle.
    lookup_en_in   = 1'b1;
    lookup_addr_in = 7'h03;
    idle(1);
    do_fill(7'h17, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677,
            128'h8899_aabb_ccdd_eeff_f0e1_d2c3_b4a5_9687,
            128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0, 3'b100, 0, 4, t0);
    idle(2);
    lookup_en_in = 1'b0;
    @(negedge clk);
    check("err_clean", LW'(fill_err_out), LW'(0));
    @(posedge clk); #1;

    // Last marker on beat 1: the error is sticky, and the line is still written.
    do_fill(7'h2A, {16{8'h11}}, {16{8'h22}}, {16{8'h33}}, 3'b110, 0, 4, t0);
    @(negedge clk);
    check("err_set", LW'(fill_err_out), LW'(1));
    @(posedge clk); #1;
    idle(3);
    @(negedge clk);
    check("err_sticky", LW'(fill_err_out), LW'(1));
    @(posedge clk); #1;

    // Reset after the second beat: the partial line is dropped, with no write and no done.
    request(7'h22, t0);
    beat({16{8'hEE}}, 1'b0, 0);
    beat({16{8'hDD}}, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_ready", LW'(mem_rd_ready_out), LW'(0));
    check("rst_mid_req_ready", LW'(fill_req_ready_out), LW'(0));
    check("rst_mid_err", LW'(fill_err_out), LW'(0));
    check("rst_mid_w_en", LW'(dm_w_en_out), LW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_state", LW'(fsm_state_out), LW'(0));
    check("rst_after_req_ready", LW'(fill_req_ready_out), LW'(1));
    @(posedge clk); #1;
    idle(5);
    do_fill(7'h40, {16{8'h5A}}, {16{8'h6B}}, {16{8'h7C}}, 3'b100, 0, 4, t0);
    idle(3);

    // Two queued requests, back to back: accepts 5 cycles apart.
    do_fill(7'h10, {16{8'h01}}, {16{8'h02}}, {16{8'h03}}, 3'b100, 0, 4, ta);
    do_fill(7'h11, {16{8'h04}}, {16{8'h05}}, {16{8'h06}}, 3'b100, 0, 4, tb);
    check("b2b_accept_gap", LW'(tb - ta), LW'(5));
    idle(4);

    check("wr_queue_drained", LW'(exp_wr_cyc_q.size()), LW'(0));
    check("done_queue_drained", LW'(exp_done_cyc_q.size()), LW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
